// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the register-file target and the APB-side master.
//   i2c_slv_state_t : target FSM states
//   I2C_RD / I2C_WR : value of the R/W bit in the address byte
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_slv_state_t;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Input conditioning for the I2C target: 2-flop synchronizers on SCL/SDA,
// a third copy for edge detection, and registered one-cycle event pulses.
//   clk, rst        : system clock, synchronous active-high reset
//   scl_i, sda_i    : asynchronous bus pins
//   scl_rise_o      : synchronized SCL rising edge
//   scl_fall_o      : synchronized SCL falling edge
//   start_o, stop_o : SDA falling / rising while SCL is high
//   sda_o           : synchronized SDA level aligned with the event pulses
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    // [0] first sync flop, [1] synchronized level, [2] previous level
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;
    logic       sda_bit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level, so leaving reset never looks like an edge.
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_q      <= {scl_q[1:0], scl_i};
            sda_q      <= {sda_q[1:0], sda_i};
            scl_rise_q <= scl_q[1] & ~scl_q[2];
            scl_fall_q <= ~scl_q[1] & scl_q[2];
            // SCL must be stably high across both samples for START/STOP.
            start_q    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
            stop_q     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
            sda_bit_q  <= sda_q[1];
        end
    end

    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_o      = sda_bit_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target serving a DEPTH-entry byte register file with an auto-incrementing
// pointer. The first byte of a write sets the pointer, following bytes are
// stored at the pointer; reads return bytes starting at the pointer.
//   clk, rst   : system clock, synchronous active-high reset
//   scl_i      : SCL pin (asynchronous)
//   sda_i      : SDA pin (asynchronous)
//   sda_oe     : 1 = pull SDA low
//   saved_data : last byte written into the register file
//   wr_stb     : one-cycle pulse per register write
//   wr_idx     : register index of the write flagged by wr_stb
//   busy       : high from START to STOP
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         DEPTH      = 8,
    localparam int        IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic [7:0]       saved_data,
    output logic             wr_stb,
    output logic [IDX_W-1:0] wr_idx,
    output logic             busy
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_bit;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_o      (sda_bit)
    );

    i2c_slv_state_t   state_q,   state_d;
    logic [3:0]       bitcnt_q,  bitcnt_d;
    logic [6:0]       shreg_q,   shreg_d;
    logic [7:0]       tx_q,      tx_d;
    logic             rw_q,      rw_d;
    logic             ack_drv_q, ack_drv_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic             sda_oe_q,  sda_oe_d;
    logic             wr_stb_q,  wr_stb_d;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic [7:0]       saved_q,   saved_d;
    logic             wr_en;

    logic [7:0]       regs_q [DEPTH];

    logic [7:0]       byte_in;
    logic [IDX_W-1:0] ptr_inc;
    logic [7:0]       cur_byte;

    // Byte as it stands once the bit sampled on this SCL rise is shifted in.
    assign byte_in  = {shreg_q, sda_bit};
    assign ptr_inc  = ptr_q + 1'b1;
    assign cur_byte = regs_q[ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            rw_q      <= I2C_WR;
            ack_drv_q <= 1'b0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
            saved_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ack_drv_q <= ack_drv_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
            saved_q   <= saved_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ack_drv_d = ack_drv_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        saved_d   = saved_q;
        wr_en     = 1'b0;

        // START outranks everything, including a coincident SCL edge.
        if (start) begin
            state_d   = ST_ADDR;
            bitcnt_d  = '0;
            ack_drv_d = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            state_d   = ST_IDLE;
            bitcnt_d  = '0;
            ack_drv_d = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d  = byte_in[6:0];
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shreg_d  = byte_in[6:0];
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            ptr_d    = byte_in[IDX_W-1:0];
                            state_d  = ST_PTR_ACK;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d  = byte_in[6:0];
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            bitcnt_d = '0;
                            wr_en    = 1'b1;
                            wr_stb_d = 1'b1;
                            wr_idx_d = ptr_q;
                            saved_d  = byte_in;
                            ptr_d    = ptr_inc;
                            state_d  = ST_WDATA_ACK;
                        end
                    end
                end

                // First falling edge after the 8th bit pulls SDA for the ACK,
                // the next one releases it and moves on.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv_q) begin
                            sda_oe_d  = 1'b1;
                            ack_drv_d = 1'b1;
                        end else begin
                            ack_drv_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q == I2C_RD) begin
                                // MSB goes out on this same falling edge.
                                state_d  = ST_RDATA;
                                sda_oe_d = ~cur_byte[7];
                                tx_d     = {cur_byte[6:0], 1'b0};
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                // tx_q[7] is always the next bit to present; bitcnt_q counts
                // bits the master has already clocked in.
                ST_RDATA: begin
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_bit) begin
                            ptr_d    = ptr_inc;
                            tx_d     = regs_q[ptr_inc];
                            bitcnt_d = '0;
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    assign sda_oe     = sda_oe_q;
    assign saved_data = saved_q;
    assign wr_stb     = wr_stb_q;
    assign wr_idx     = wr_idx_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
